mp_addsub_serial: RTL and testbench

//   Parametrised multi-precision adder/subtractor, next generation of the 1027-bit start/done adder.

---
 rtl/mp_addsub_serial_if.sv | 38 +++
 rtl/mp_addsub_serial.sv | 114 +++++++++++
 tb/tb_mp_addsub_serial.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mp_addsub_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : mp_addsub_serial_if
// Purpose  : Request/result bundle for the limb-serial multi-precision
//            adder/subtractor. The chain signal exists only with MPADD_CHAIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface mp_addsub_serial_if #(
    parameter int WIDTH = 1027
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
`ifdef MPADD_CHAIN_EN
    logic             chain;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;

    modport master (
        output start, subtract, in_a, in_b,
`ifdef MPADD_CHAIN_EN
        output chain,
`endif
        input  busy, done, result
    );

    modport slave (
        input  start, subtract, in_a, in_b,
`ifdef MPADD_CHAIN_EN
        input  chain,
`endif
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/mp_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : mp_addsub_serial
// Purpose  : Multi-precision A+B / A-B, one LIMB-wide slice per cycle with a
//            registered carry. Optional MPADD_CHAIN_EN reuses result as A.
// Revision : 1.0 - initial release
// ============================================================================
module mp_addsub_serial #(
    parameter int WIDTH = 1027,
    parameter int LIMB  = 64
) (
    input  logic                clk,
    input  logic                reset,
    mp_addsub_serial_if.slave   bus
);
    localparam int NLIMB = (WIDTH + 1 + LIMB - 1) / LIMB;
    localparam int EXT   = NLIMB * LIMB;
    localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NLIMB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_carry;
    logic            r_sub;
    logic [EXT-1:0]  r_a;
    logic [EXT-1:0]  r_b;
    logic [EXT-1:0]  r_acc;

    logic [LIMB-1:0] w_b_limb;
    logic [LIMB:0]   w_sum;
    logic [EXT-1:0]  w_acc_next;
    logic [WIDTH-1:0] w_a_src;
    int              w_base;

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_comb begin
        w_b_limb   = r_sub ? ~r_b[LIMB-1:0] : r_b[LIMB-1:0];
        w_sum      = {1'b0, r_a[LIMB-1:0]} + {1'b0, w_b_limb} + {{LIMB{1'b0}}, r_carry};
        w_base     = int'(r_cnt) * LIMB;
        w_acc_next = r_acc;
        w_acc_next[w_base +: LIMB] = w_sum[LIMB-1:0];
    end

`ifdef MPADD_CHAIN_EN
    assign w_a_src = bus.chain ? bus.result[WIDTH-1:0] : bus.in_a;
`else
    assign w_a_src = bus.in_a;
`endif

    generate
        if (EXT > WIDTH + 1) begin : g_pad
            // Padding bits of the last limb are computed but intentionally dropped.
            logic w_pad_unused;
            assign w_pad_unused = ^w_acc_next[EXT-1:WIDTH+1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= S_RUN;
                        r_cnt    <= '0;
                        r_carry  <= bus.subtract;
                        r_sub    <= bus.subtract;
                        r_a      <= EXT'(w_a_src);
                        r_b      <= EXT'(bus.in_b);
                        bus.busy <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_sum[LIMB];
                    r_a     <= r_a >> LIMB;
                    r_b     <= r_b >> LIMB;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST) begin
                        r_state    <= S_DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.result <= w_acc_next[WIDTH:0];
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mp_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_addsub_serial
// Purpose  : Directed and random checks of mp_addsub_serial against a plain
//            arithmetic model. Chain steps run when MPADD_CHAIN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_addsub_serial;
    localparam int WIDTH = 1027;
    localparam int LIMB  = 64;
    localparam int NLIMB = (WIDTH + 1 + LIMB - 1) / LIMB;
    localparam int LW    = WIDTH + 1;
    localparam int NW    = (WIDTH + 31) / 32;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    logic [WIDTH:0] model_result;

    mp_addsub_serial_if #(.WIDTH(WIDTH)) bus ();

    mp_addsub_serial #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h..%h expected=%h..%h", tag,
                   obs[WIDTH -: 4], obs[159:0], exp[WIDTH -: 4], exp[159:0]);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_wide();
        logic [32*NW-1:0] t;
        for (int i = 0; i < NW; i++) t[i*32 +: 32] = $urandom;
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sub);
        return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic ch);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.subtract = sub;
`ifdef MPADD_CHAIN_EN
        bus.chain    = ch;
`else
        if (ch) $display("note: chain request ignored in base build");
`endif
    endtask

    // Waits for done after the accepting edge; returns edges elapsed.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < NLIMB + 5) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic ch);
        logic [WIDTH-1:0] a_eff;
        logic [WIDTH:0]   exp;
        int n;
        a_eff = ch ? model_result[WIDTH-1:0] : a;
        exp   = ref_op(a_eff, b, sub);
        @(negedge clk);
        drive(a, b, sub, ch);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drive(~a, ~b, ~sub, 1'b0);
        check({tag, "_busy"}, LW'(bus.busy), LW'(1));
        check({tag, "_held"}, bus.result, model_result);
        wait_done(n);
        check({tag, "_latency"}, LW'(n), LW'(NLIMB));
        check({tag, "_result"}, bus.result, exp);
        @(negedge clk);
        check({tag, "_pulse"}, LW'(bus.done), LW'(0));
        model_result = exp;
    endtask

    initial begin
        logic [WIDTH-1:0] a1, b1, a2, b2;
        logic [WIDTH:0]   e1, e2;
        logic             s;
        int               n, dones;
        n_assert = 0;
        n_fail   = 0;
        model_result = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy",   LW'(bus.busy), LW'(0));
        check("rst_done",   LW'(bus.done), LW'(0));
        check("rst_result", bus.result, '0);
        reset = 1'b0;

        run_op("add_c_d", WIDTH'('hc), WIDTH'('hd), 1'b0, 1'b0);
        check("add_c_d_val", bus.result, LW'('h19));
        run_op("sub_2_2", WIDTH'(2), WIDTH'(2), 1'b1, 1'b0);
        check("sub_2_2_val", bus.result, '0);
        run_op("sub_0_1", '0, WIDTH'(1), 1'b1, 1'b0);
        check("sub_0_1_ones", bus.result, '1);
        run_op("carry64", WIDTH'(64'hFFFF_FFFF_FFFF_FFFF), WIDTH'(1), 1'b0, 1'b0);
        check("carry64_val", bus.result, LW'(1) << 64);
        run_op("max_add", '1, '1, 1'b0, 1'b0);
        check("max_add_val", bus.result, {{WIDTH{1'b1}}, 1'b0});

        for (int i = 0; i < 8; i++) begin
            a1 = rand_wide();
            b1 = (i == 3) ? a1 : rand_wide();
            run_op($sformatf("rand%0d", i), a1, b1, 1'($urandom_range(0, 1)), 1'b0);
        end

        // start held during RUN must not disturb the running operation
        a1 = rand_wide(); b1 = rand_wide(); e1 = ref_op(a1, b1, 1'b0);
        @(negedge clk);
        drive(a1, b1, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        drive(rand_wide(), rand_wide(), 1'b1, 1'b0);
        n = 0;
        repeat (4) begin @(negedge clk); n++; end
        bus.start = 1'b0;
        check("hold_busy", LW'(bus.busy), LW'(1));
        while (bus.done !== 1'b1 && n < NLIMB + 5) begin @(negedge clk); n++; end
        check("hold_latency", LW'(n), LW'(NLIMB));
        check("hold_result", bus.result, e1);

        // back-to-back accept during the DONE cycle
        a2 = rand_wide(); b2 = rand_wide(); s = 1'b1; e2 = ref_op(a2, b2, s);
        drive(a2, b2, s, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", LW'(bus.busy), LW'(1));
        check("b2b_done_low", LW'(bus.done), LW'(0));
        check("b2b_held", bus.result, e1);
        wait_done(n);
        check("b2b_latency", LW'(n), LW'(NLIMB));
        check("b2b_result", bus.result, e2);
        @(negedge clk);
        check("b2b_pulse", LW'(bus.done), LW'(0));
        model_result = e2;

        // reset mid-RUN aborts without a done pulse
        @(negedge clk);
        drive(rand_wide(), rand_wide(), 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   LW'(bus.busy), LW'(0));
        check("abort_done",   LW'(bus.done), LW'(0));
        check("abort_result", bus.result, '0);
        dones = 0;
        repeat (NLIMB + 3) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", LW'(dones), LW'(0));
        model_result = '0;

`ifdef MPADD_CHAIN_EN
        run_op("chain_base", WIDTH'(5), WIDTH'(7), 1'b0, 1'b0);
        check("chain_base_val", bus.result, LW'(12));
        run_op("chain_on", WIDTH'(100), WIDTH'(3), 1'b0, 1'b1);
        check("chain_on_val", bus.result, LW'(15));
        run_op("chain_off", WIDTH'(20), WIDTH'(3), 1'b0, 1'b0);
        check("chain_off_val", bus.result, LW'(23));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
